// File: rtl/bytecode_fetch_ctrl_pkg.sv
// Shared constants and types for the bytecode fetch controller: state encoding,
// special opcodes and the length-decode record.
package bytecode_fetch_ctrl_pkg;

    localparam int ADDRESS_WIDTH_DEFAULT = 16;
    localparam int MAX_OPERANDS          = 4;

    localparam logic [7:0] OP_WIDE = 8'hC4;
    localparam logic [7:0] OP_IINC = 8'h84;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_OPERAND,
        ST_WIDE_OP,
        ST_HOLD,
        ST_REDIR,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic [2:0] count;
        logic       unsupported;
        logic       is_wide;
    } len_info_t;

    // Operand count of an opcode following a wide prefix; 0 means not widenable.
    function automatic logic [2:0] wide_operand_count(input logic [7:0] op);
        logic [2:0] cnt;
        cnt = 3'd0;
        if (op == OP_IINC) begin
            cnt = 3'(MAX_OPERANDS);
        end else if (op inside {[8'h15:8'h19], [8'h36:8'h3A], 8'hA9}) begin
            cnt = 3'd2;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bytecode_fetch_ctrl_if.sv
// Instruction hand-off bus from the fetch controller to the decoder/translator.
interface bytecode_fetch_ctrl_if #(
    parameter int ADDRESS_WIDTH = bytecode_fetch_ctrl_pkg::ADDRESS_WIDTH_DEFAULT
);
    logic                     insn_valid;
    logic                     insn_ready;
    logic [7:0]               insn_opcode;
    logic [31:0]              insn_operands;
    logic [2:0]               insn_nops;
    logic [ADDRESS_WIDTH-1:0] insn_pc;
    logic                     insn_wide;

    modport master (
        output insn_valid, insn_opcode, insn_operands, insn_nops, insn_pc, insn_wide,
        input  insn_ready
    );

    modport slave (
        input  insn_valid, insn_opcode, insn_operands, insn_nops, insn_pc, insn_wide,
        output insn_ready
    );
endinterface

// File: rtl/bytecode_fetch_ctrl_bc_length_rom.sv
// bc_length_rom: combinational JVM opcode -> {operand count, unsupported, is_wide}.
module bc_length_rom
    import bytecode_fetch_ctrl_pkg::*;
(
    input  logic [7:0] opcode,
    output len_info_t  info
);

    always_comb begin
        info = '0;
        case (opcode) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
                info.count = 3'd1;
            8'h11, 8'h13, 8'h14, OP_IINC, [8'h99:8'hA8], [8'hB2:8'hB8],
            8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
                info.count = 3'd2;
            8'hC5:
                info.count = 3'd3;
            8'hB9, 8'hBA, 8'hC8, 8'hC9:
                info.count = 3'd4;
            8'hAA, 8'hAB, [8'hCA:8'hFF]:
                info.unsupported = 1'b1;
            OP_WIDE:
                info.is_wide = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/bytecode_fetch_ctrl.sv
// Drives next_byte_gen to assemble JVM instructions (opcode + 0-4 operands).
// Define BC_WIDE_PREFIX_EN to enable wide-prefix (0xC4) handling.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | instruction boundary, waiting for run
// ST_OPCODE  | fetching opcode byte
// ST_OPERAND | fetching remaining operand bytes
// ST_WIDE_OP | fetching the opcode that follows a wide prefix
// ST_HOLD    | instruction presented, waiting for insn_ready
// ST_REDIR   | fetcher PC reload pulse after a redirect
// ST_HALT    | undecodable opcode seen, parked until redirect/reset
module bytecode_fetch_ctrl
    import bytecode_fetch_ctrl_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     pc_reset,
    input  logic                     run,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     fetch_start,
    input  logic [7:0]               fetch_byte,
    input  logic                     fetch_ready,
    output logic                     gen_pc_reset_n,
    output logic [ADDRESS_WIDTH-1:0] gen_pc_value,
    output logic                     unsupported,
    bytecode_fetch_ctrl_if.master    insn
);

`ifdef BC_WIDE_PREFIX_EN
    localparam bit WIDE_EN = 1'b1;
`else
    localparam bit WIDE_EN = 1'b0;
`endif

    state_e                   state_q, state_d;
    logic                     fetch_start_q, fetch_start_d;
    logic                     insn_valid_q, insn_valid_d;
    logic [7:0]               opcode_q, opcode_d;
    logic [31:0]              operands_q, operands_d;
    logic [2:0]               nops_q, nops_d;
    logic [2:0]               remaining_q, remaining_d;
    logic [ADDRESS_WIDTH-1:0] insn_pc_q, insn_pc_d;
    logic [ADDRESS_WIDTH-1:0] shadow_pc_q, shadow_pc_d;
    logic [ADDRESS_WIDTH-1:0] gen_pc_value_q, gen_pc_value_d;
    logic                     wide_q, wide_d;
    logic                     unsupported_q, unsupported_d;
    logic                     redir_n_q, redir_n_d;

    logic                     xfer;
    len_info_t                rom_info;
    logic [2:0]               wide_count;

    bc_length_rom u_length_rom (
        .opcode (fetch_byte),
        .info   (rom_info)
    );

    assign xfer       = fetch_start_q & fetch_ready;
    assign wide_count = wide_operand_count(fetch_byte);

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        operands_d     = operands_q;
        nops_d         = nops_q;
        remaining_d    = remaining_q;
        insn_pc_d      = insn_pc_q;
        shadow_pc_d    = shadow_pc_q;
        gen_pc_value_d = gen_pc_value_q;
        wide_d         = wide_q;
        unsupported_d  = unsupported_q;
        redir_n_d      = 1'b1;

        if (xfer) begin
            shadow_pc_d = shadow_pc_q + ADDRESS_WIDTH'(1);
        end

        // Redirect outranks everything, including a byte accepted this cycle.
        if (redirect) begin
            state_d        = ST_REDIR;
            shadow_pc_d    = redirect_pc;
            gen_pc_value_d = redirect_pc;
            redir_n_d      = 1'b0;
            unsupported_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) state_d = ST_OPCODE;
                end
                ST_OPCODE: begin
                    if (xfer) begin
                        opcode_d    = fetch_byte;
                        insn_pc_d   = shadow_pc_q;
                        operands_d  = '0;
                        nops_d      = rom_info.count;
                        remaining_d = rom_info.count;
                        wide_d      = 1'b0;
                        if (rom_info.unsupported || (rom_info.is_wide && !WIDE_EN)) begin
                            state_d       = ST_HALT;
                            unsupported_d = 1'b1;
                        end else if (rom_info.is_wide) begin
                            state_d = ST_WIDE_OP;
                            wide_d  = 1'b1;
                        end else if (rom_info.count == 3'd0) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_OPERAND;
                        end
                    end
                end
                ST_WIDE_OP: begin
                    if (xfer) begin
                        opcode_d    = fetch_byte;
                        nops_d      = wide_count;
                        remaining_d = wide_count;
                        if (wide_count == 3'd0) begin
                            state_d       = ST_HALT;
                            unsupported_d = 1'b1;
                        end else begin
                            state_d = ST_OPERAND;
                        end
                    end
                end
                ST_OPERAND: begin
                    if (xfer) begin
                        operands_d  = {operands_q[23:0], fetch_byte};
                        remaining_d = remaining_q - 3'd1;
                        if (remaining_q == 3'd1) state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (insn.insn_ready) state_d = run ? ST_OPCODE : ST_IDLE;
                end
                ST_REDIR: state_d = ST_IDLE;
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_IDLE;
            endcase
        end

        fetch_start_d = (state_d == ST_OPCODE) || (state_d == ST_OPERAND) ||
                        (state_d == ST_WIDE_OP);
        insn_valid_d  = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            state_q        <= ST_IDLE;
            fetch_start_q  <= 1'b0;
            insn_valid_q   <= 1'b0;
            opcode_q       <= '0;
            operands_q     <= '0;
            nops_q         <= '0;
            remaining_q    <= '0;
            insn_pc_q      <= '0;
            shadow_pc_q    <= RESET_PC;
            gen_pc_value_q <= RESET_PC;
            wide_q         <= 1'b0;
            unsupported_q  <= 1'b0;
            redir_n_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            fetch_start_q  <= fetch_start_d;
            insn_valid_q   <= insn_valid_d;
            opcode_q       <= opcode_d;
            operands_q     <= operands_d;
            nops_q         <= nops_d;
            remaining_q    <= remaining_d;
            insn_pc_q      <= insn_pc_d;
            shadow_pc_q    <= shadow_pc_d;
            gen_pc_value_q <= gen_pc_value_d;
            wide_q         <= wide_d;
            unsupported_q  <= unsupported_d;
            redir_n_q      <= redir_n_d;
        end
    end

    // Registered pulse gated only by reset keeps the fetcher reset glitch-free.
    assign gen_pc_reset_n     = pc_reset & redir_n_q;
    assign gen_pc_value       = gen_pc_value_q;
    assign fetch_start        = fetch_start_q;
    assign unsupported        = unsupported_q;
    assign insn.insn_valid    = insn_valid_q;
    assign insn.insn_opcode   = opcode_q;
    assign insn.insn_operands = operands_q;
    assign insn.insn_nops     = nops_q;
    assign insn.insn_pc       = insn_pc_q;
    assign insn.insn_wide     = WIDE_EN & wide_q;

endmodule

// File: tb/tb_bytecode_fetch_ctrl.sv
// Self-checking bench for bytecode_fetch_ctrl with a behavioural next_byte_gen
// and a scoreboard of expected instructions.
module tb_bytecode_fetch_ctrl;
    import bytecode_fetch_ctrl_pkg::*;

    localparam int AW = 16;

    typedef struct packed {
        logic [7:0]    opcode;
        logic [31:0]   operands;
        logic [2:0]    nops;
        logic [AW-1:0] pc;
        logic          wide;
    } insn_t;

    logic          clk = 1'b0;
    logic          pc_reset;
    logic          run;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          fetch_start;
    logic [7:0]    fetch_byte;
    logic          fetch_ready;
    logic          gen_pc_reset_n;
    logic [AW-1:0] gen_pc_value;
    logic          unsupported;

    bytecode_fetch_ctrl_if #(.ADDRESS_WIDTH(AW)) insn_if ();

    bytecode_fetch_ctrl #(.ADDRESS_WIDTH(AW), .RESET_PC('0)) dut (
        .clk            (clk),
        .pc_reset       (pc_reset),
        .run            (run),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fetch_start    (fetch_start),
        .fetch_byte     (fetch_byte),
        .fetch_ready    (fetch_ready),
        .gen_pc_reset_n (gen_pc_reset_n),
        .gen_pc_value   (gen_pc_value),
        .unsupported    (unsupported),
        .insn           (insn_if)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         xfer_cyc[$];
    insn_t      exp_q[$];
    logic [7:0] mem [256];
    logic [AW-1:0] gen_pc;
    bit         toggle_en = 1'b0;

    // Behavioural byte fetcher
    always @(posedge clk) begin
        if (!gen_pc_reset_n)               gen_pc <= gen_pc_value;
        else if (fetch_start && fetch_ready) gen_pc <= gen_pc + 16'd1;
    end
    assign fetch_byte = mem[gen_pc[7:0]];

    initial begin
        fetch_ready = 1'b1;
        forever begin
            @(negedge clk);
            fetch_ready = toggle_en ? ~fetch_ready : 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (pc_reset === 1'b1 && fetch_start === 1'b1 && fetch_ready === 1'b1)
                xfer_cyc.push_back(cyc);
            cyc = cyc + 1;
        end
    end

    function automatic insn_t cur_insn();
        insn_t c;
        c.opcode   = insn_if.insn_opcode;
        c.operands = insn_if.insn_operands;
        c.nops     = insn_if.insn_nops;
        c.pc       = insn_if.insn_pc;
        c.wide     = insn_if.insn_wide;
        return c;
    endfunction

    task automatic wait_valid(input int budget, output bit ok, output insn_t got, output int at);
        ok = 1'b0; got = '0; at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (insn_if.insn_valid === 1'b1) begin
                ok = 1'b1; got = cur_insn(); at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_unsup(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (unsupported === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic restart(input logic [AW-1:0] addr);
        run = 1'b0; insn_if.insn_ready = 1'b1; toggle_en = 1'b0;
        repeat (8) @(negedge clk);
        redirect = 1'b1; redirect_pc = addr;
        @(negedge clk);
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        xfer_cyc.delete();
    endtask

    task automatic test_reset();
        pc_reset = 1'b0; run = 1'b0; redirect = 1'b0; redirect_pc = '0;
        insn_if.insn_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (fetch_start !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_start got %b want 0", fetch_start); end
        n_checks++; if (insn_if.insn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", insn_if.insn_valid); end
        n_checks++; if (unsupported !== 1'b0) begin n_fail++; $display("FAIL reset_unsupported got %b want 0", unsupported); end
        n_checks++; if (gen_pc_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_gen_pc_reset_n got %b want 0", gen_pc_reset_n); end
        n_checks++; if (gen_pc_value !== 16'h0) begin n_fail++; $display("FAIL reset_gen_pc_value got %h want 0000", gen_pc_value); end
        n_checks++; if (cur_insn() !== insn_t'(0)) begin n_fail++; $display("FAIL reset_insn_fields got %h want 0", cur_insn()); end
        pc_reset = 1'b1;
        @(negedge clk);
        n_checks++; if (gen_pc_reset_n !== 1'b1) begin n_fail++; $display("FAIL release_gen_pc_reset_n got %b want 1", gen_pc_reset_n); end
        n_checks++; if (fetch_start !== 1'b0) begin n_fail++; $display("FAIL idle_fetch_start got %b want 0", fetch_start); end
    endtask

    task automatic test_nop_stream();
        bit ok; insn_t got, exp; int at; int prev;
        prev = 0;
        for (int k = 0; k < 3; k++) exp_q.push_back('{8'h00, 32'h0, 3'd0, 16'(k), 1'b0});
        insn_if.insn_ready = 1'b1; run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(30, ok, got, at);
            if (k == 2) run = 1'b0;
            exp = exp_q.pop_front();
            n_checks++; if (!ok) begin n_fail++; $display("FAIL nop_timeout got no valid want insn %0d", k); end
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL nop_insn got %h want %h", got, exp); end
            if (k > 0) begin
                n_checks++; if (at - prev != 2) begin n_fail++; $display("FAIL nop_spacing got %0d want 2", at - prev); end
            end
            prev = at;
        end
    endtask

    task automatic test_sipush_hold();
        bit ok; insn_t got, exp; int at;
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h12; mem[8'h12] = 8'h34;
        restart(16'h0010);
        exp_q.push_back('{8'h11, 32'h0000_1234, 3'd2, 16'h0010, 1'b0});
        insn_if.insn_ready = 1'b0; run = 1'b1;
        wait_valid(30, ok, got, at);
        run = 1'b0;
        exp = exp_q.pop_front();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sipush_timeout got no valid want valid"); end
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL sipush_insn got %h want %h", got, exp); end
        n_checks++;
        if (xfer_cyc.size() != 3 || at != xfer_cyc[0] + 3) begin
            n_fail++; $display("FAIL sipush_latency got xfers=%0d valid_cyc=%0d want 3 xfers, opcode+3", xfer_cyc.size(), at);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (insn_if.insn_valid !== 1'b1 || fetch_start !== 1'b0 || cur_insn() !== exp) begin
                n_fail++; $display("FAIL sipush_hold_stable got v=%b fs=%b %h want v=1 fs=0 %h",
                                   insn_if.insn_valid, fetch_start, cur_insn(), exp);
            end
        end
        n_checks++; if (xfer_cyc.size() != 3) begin n_fail++; $display("FAIL sipush_hold_xfers got %0d want 3", xfer_cyc.size()); end
        insn_if.insn_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (insn_if.insn_valid !== 1'b0) begin n_fail++; $display("FAIL sipush_accept got valid %b want 0", insn_if.insn_valid); end
    endtask

    task automatic test_goto_w_stall();
        bit ok; insn_t got, exp; int at;
        mem[8'h20] = 8'hC8; mem[8'h21] = 8'hDE; mem[8'h22] = 8'hAD; mem[8'h23] = 8'hBE; mem[8'h24] = 8'hEF;
        restart(16'h0020);
        exp_q.push_back('{8'hC8, 32'hDEAD_BEEF, 3'd4, 16'h0020, 1'b0});
        toggle_en = 1'b1; run = 1'b1;
        wait_valid(80, ok, got, at);
        run = 1'b0; toggle_en = 1'b0;
        exp = exp_q.pop_front();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL goto_w_timeout got no valid want valid"); end
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL goto_w_insn got %h want %h", got, exp); end
        n_checks++; if (xfer_cyc.size() != 5) begin n_fail++; $display("FAIL goto_w_xfers got %0d want 5", xfer_cyc.size()); end
    endtask

    task automatic test_wide();
        bit ok;
        mem[8'h30] = 8'hC4; mem[8'h31] = 8'h84; mem[8'h32] = 8'h01;
        mem[8'h33] = 8'h02; mem[8'h34] = 8'h00; mem[8'h35] = 8'h05;
        restart(16'h0030);
        run = 1'b1;
`ifdef BC_WIDE_PREFIX_EN
        begin
            insn_t got, exp; int at;
            exp_q.push_back('{8'h84, 32'h0102_0005, 3'd4, 16'h0030, 1'b1});
            wait_valid(40, ok, got, at);
            run = 1'b0;
            exp = exp_q.pop_front();
            n_checks++; if (!ok) begin n_fail++; $display("FAIL wide_timeout got no valid want valid"); end
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL wide_insn got %h want %h", got, exp); end
            n_checks++; if (unsupported !== 1'b0) begin n_fail++; $display("FAIL wide_unsupported got %b want 0", unsupported); end
        end
`else
        wait_unsup(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wide_off_unsupported got 0 want 1"); end
        n_checks++; if (insn_if.insn_valid !== 1'b0) begin n_fail++; $display("FAIL wide_off_valid got %b want 0", insn_if.insn_valid); end
        n_checks++; if (fetch_start !== 1'b0) begin n_fail++; $display("FAIL wide_off_fetch_start got %b want 0", fetch_start); end
        n_checks++; if (xfer_cyc.size() != 1) begin n_fail++; $display("FAIL wide_off_xfers got %0d want 1", xfer_cyc.size()); end
`endif
    endtask

    task automatic test_halt_redirect();
        bit ok; insn_t got; int at;
        mem[8'h07] = 8'hAA;
        restart(16'h0007);
        run = 1'b1;
        wait_unsup(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL halt_unsupported got 0 want 1"); end
        repeat (3) @(negedge clk);
        n_checks++; if (fetch_start !== 1'b0 || insn_if.insn_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_parked got fs=%b v=%b want 0 0", fetch_start, insn_if.insn_valid); end
        n_checks++; if (xfer_cyc.size() != 1 || unsupported !== 1'b1) begin
            n_fail++; $display("FAIL halt_sticky got xfers=%0d unsup=%b want 1 1", xfer_cyc.size(), unsupported); end
        redirect = 1'b1; redirect_pc = 16'h0020;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++; if (gen_pc_reset_n !== 1'b0) begin n_fail++; $display("FAIL redir_pulse got %b want 0", gen_pc_reset_n); end
        n_checks++; if (gen_pc_value !== 16'h0020) begin n_fail++; $display("FAIL redir_value got %h want 0020", gen_pc_value); end
        n_checks++; if (unsupported !== 1'b0) begin n_fail++; $display("FAIL redir_unsup_clear got %b want 0", unsupported); end
        n_checks++; if (fetch_start !== 1'b0) begin n_fail++; $display("FAIL redir_fs_r1 got %b want 0", fetch_start); end
        @(negedge clk);
        n_checks++; if (gen_pc_reset_n !== 1'b1 || fetch_start !== 1'b0) begin
            n_fail++; $display("FAIL redir_r2 got rn=%b fs=%b want 1 0", gen_pc_reset_n, fetch_start); end
        @(negedge clk);
        n_checks++; if (fetch_start !== 1'b1) begin n_fail++; $display("FAIL redir_fs_r3 got %b want 1", fetch_start); end
        wait_valid(30, ok, got, at);
        run = 1'b0;
        n_checks++; if (!ok || got !== insn_t'({8'hC8, 32'hDEAD_BEEF, 3'd4, 16'h0020, 1'b0})) begin
            n_fail++; $display("FAIL redir_target_insn got ok=%b %h want C8 DEADBEEF at 0020", ok, got); end
    endtask

    task automatic test_redirect_mid();
        bit ok, found; insn_t got, exp; int at;
        mem[8'h40] = 8'h11; mem[8'h41] = 8'h12; mem[8'h42] = 8'h34;
        mem[8'h50] = 8'h00; mem[8'h51] = 8'h00;
        restart(16'h0040);
        exp_q.push_back('{8'h00, 32'h0, 3'd0, 16'h0050, 1'b0});
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (xfer_cyc.size() == 2) begin found = 1'b1; break; end
        end
        n_checks++; if (!found || fetch_start !== 1'b1) begin
            n_fail++; $display("FAIL mid_reach_operand2 got found=%b fs=%b want 1 1", found, fetch_start); end
        redirect = 1'b1; redirect_pc = 16'h0050;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++; if (insn_if.insn_valid !== 1'b0) begin n_fail++; $display("FAIL mid_partial_valid got %b want 0", insn_if.insn_valid); end
        wait_valid(30, ok, got, at);
        run = 1'b0;
        exp = exp_q.pop_front();
        n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL mid_next_insn got ok=%b %h want %h", ok, got, exp); end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        test_reset();
        test_nop_stream();
        test_sipush_hold();
        test_goto_w_stall();
        test_wide();
        test_halt_redirect();
        test_redirect_mid();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bytecode_fetch_ctrl.md
# bytecode_fetch_ctrl

Sequences the byte fetcher (next_byte_gen) to assemble complete JVM instructions: opcode plus 0–4 big-endian operand bytes, tagged with opcode PC. Sits between the byte fetcher and the decoder/translator. Owns the fetcher's `start` handshake and its PC-load/reset path for branch redirects. Halts on opcodes it cannot length-decode.

## Interface
Parameters:
- ADDRESS_WIDTH, default `ADDRESS_WIDTH from me_consts.vh: PC width.
- RESET_PC, default 0: fetch address after pc_reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- pc_reset  in  1  reset, asynchronous, active-low.
- run  in  1  permits fetching a new opcode; sampled only at instruction boundaries.
- redirect  in  1  one-cycle pulse: discard current work, restart at redirect_pc.
- redirect_pc  in  ADDRESS_WIDTH  target of redirect.
- fetch_start  out  1  to next_byte_gen.start.
- fetch_byte  in  8  from next_byte_gen.next_byte.
- fetch_ready  in  1  from next_byte_gen.ready.
- gen_pc_reset_n  out  1  to next_byte_gen.pc_reset.
- gen_pc_value  out  ADDRESS_WIDTH  to next_byte_gen.pc_reset_value.
- insn_valid  out  1  instruction available.
- insn_ready  in  1  downstream accepts.
- insn_opcode  out  8  opcode (after any wide prefix).
- insn_operands  out  32  operand bytes, right-aligned big-endian.
- insn_nops  out  3  operand byte count, 0–4.
- insn_pc  out  ADDRESS_WIDTH  PC of first byte (prefix if wide).
- insn_wide  out  1  instruction carried a wide prefix.
- unsupported  out  1  sticky: undecodable opcode hit.

## Operation
- Byte transfer = cycle with fetch_start=1 and fetch_ready=1; fetch_byte is consumed that cycle and the fetcher PC increments. Controller keeps a shadow PC incremented on every transfer.
- States: IDLE, OPCODE, OPERAND, WIDE_OP, HOLD, REDIR, HALT.
- IDLE: fetch_start=0; run=1 → OPCODE.
- OPCODE: fetch_start=1. On transfer: latch opcode, insn_pc=shadow PC, clear operands, load remaining count from length ROM. Count 0 → HOLD; count>0 → OPERAND; 0xC4 → WIDE_OP; unsupported → HALT.
- OPERAND: fetch_start=1; each transfer operands={operands[23:0],byte}, decrement; last → HOLD.
- WIDE_OP: fetch next opcode; 0x84 (iinc) → 4 operands; 0x15–0x19, 0x36–0x3A, 0xA9 → 2 operands; any other → HALT. insn_wide=1.
- HOLD: insn_valid=1, fetch_start=0. insn_ready=1 → run ? OPCODE : IDLE.
- Length ROM: 1 byte: 0x10,0x12,0x15–0x19,0x36–0x3A,0xA9,0xBC. 2: 0x11,0x13,0x14,0x84,0x99–0xA8,0xB2–0xB8,0xBB,0xBD,0xC0,0xC1,0xC6,0xC7. 3: 0xC5. 4: 0xB9,0xBA,0xC8,0xC9. Unsupported: 0xAA,0xAB,0xCA–0xFF. All others 0.
- HALT: fetch_start=0, insn_valid=0, unsupported=1; exit only by redirect or pc_reset.
- redirect (any state, highest priority): next cycle REDIR: insn_valid=0, fetch_start=0, gen_pc_value=redirect_pc, gen_pc_reset_n=0 for exactly that cycle; shadow PC=redirect_pc; unsupported cleared. Then IDLE. Redirect while in REDIR restarts REDIR with newest target.
- gen_pc_reset_n = pc_reset AND registered redirect-pulse-n (glitch-free register output ANDed only with reset).

## Timing
- Reset: state IDLE, all insn_* 0, fetch_start 0, unsupported 0, gen_pc_value=RESET_PC, shadow PC=RESET_PC, gen_pc_reset_n follows pc_reset.
- Opcode transfer in cycle N with k operands transferred back-to-back → insn_valid in cycle N+k+1.
- Fetch stalls while fetch_ready=0; no byte consumed.
- One bubble: HOLD accepted in cycle M → fetch_start=1 no earlier than M+1.
- insn_* stable while insn_valid=1 and insn_ready=0.
- redirect in cycle R → gen_pc_reset_n low in R+1, fetch_start=1 earliest R+3.

## Configuration
- BC_WIDE_PREFIX_EN defined: WIDE_OP state and wide handling as above.
- Undefined: 0xC4 treated as unsupported → HALT; insn_wide tied 0.

## Structure
- Shared package/header (me_consts.vh style): state encodings, opcode constants (WIDE=0xC4, IINC=0x84), max operand count 4.
- Sub-module bc_length_rom: combinational opcode → {count[2:0], unsupported, is_wide}.

## Test plan
- Reset, run=1, memory 0x00 0x00 0x00 → three insns, nops=0, insn_pc 0,1,2.
- sipush 0x11 0x12 0x34, insn_ready held 0 for 5 cycles → operands 0x00001234, nops=2, stable, no fetch_start during hold.
- goto_w 0xC8 0xDE 0xAD 0xBE 0xEF with fetch_ready toggling → operands 0xDEADBEEF, nops=4.
- Wide: 0xC4 0x84 0x01 0x02 0x00 0x05 → opcode 0x84, wide=1, operands 0x01020005, insn_pc at prefix; without macro → unsupported=1.
- 0xAA at PC 7 → HALT, unsupported=1, fetch_start=0; redirect to 0x20 → unsupported=0, gen_pc_reset_n low one cycle, gen_pc_value=0x20.
- redirect during second operand of sipush → partial insn never valid; next insn_pc=redirect_pc.
